// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - hazard detection, forwarding and MDU scoreboard for the 5-stage pipeline
module hazard_scoreboard_unit #(
  parameter int ADDR_W  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr_D_i,
  input  logic [ADDR_W-1:0] rs2_addr_D_i,
  input  logic [ADDR_W-1:0] rs1_addr_E_i,
  input  logic [ADDR_W-1:0] rs2_addr_E_i,
  input  logic [ADDR_W-1:0] rd_addr_E_i,
  input  logic              rd_wr_E_i,
  input  logic              mdu_op_E_i,
  input  logic              kill_E_i,
  input  logic              rd_wr_M_i,
  input  logic [ADDR_W-1:0] rd_addr_M_i,
  input  logic              is_load_M_i,
  input  logic              rd_wr_W_i,
  input  logic [ADDR_W-1:0] rd_addr_W_i,
  output logic [1:0]        fwd_rs1_E_o,
  output logic [1:0]        fwd_rs2_E_o,
  output logic [1:0]        fwd_rs1_D_o,
  output logic [1:0]        fwd_rs2_D_o,
  output logic              stall_o,
  output logic              bubble_M_o,
  output logic              mdu_issue_o,
  output logic              mdu_wb_valid_o,
  output logic [ADDR_W-1:0] mdu_wb_rd_o,
  output logic [CNT_W-1:0]  mdu_inflight_o
);

  // Scoreboard: one slot per MDU pipeline stage; slot MDU_LAT-1 is the completing result.
  logic [MDU_LAT-1:0] sb_valid;
  logic [ADDR_W-1:0]  sb_rd [MDU_LAT];
  logic [CNT_W-1:0]   inflight_q;

  // Match against a live entry still ahead of the tail (result not yet available).
  function automatic logic pending(input logic [ADDR_W-1:0] r);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      if (sb_valid[i] && (sb_rd[i] != '0) && (sb_rd[i] == r)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Match against the live tail entry, whose result is on the writeback bus this cycle.
  function automatic logic tail(input logic [ADDR_W-1:0] r);
    return sb_valid[MDU_LAT-1] && (sb_rd[MDU_LAT-1] != '0) && (sb_rd[MDU_LAT-1] == r);
  endfunction

  // E-stage operand select: MDU tail is youngest producer, then M (non-load), then W.
  function automatic logic [1:0] fwd_e(input logic [ADDR_W-1:0] s);
    if (s == '0)                                              return 2'b00;
    else if (tail(s))                                         return 2'b11;
    else if (rd_wr_M_i && !is_load_M_i && (rd_addr_M_i == s)) return 2'b10;
    else if (rd_wr_W_i && (rd_addr_W_i == s))                 return 2'b01;
    else                                                      return 2'b00;
  endfunction

  // D-stage operand select: MDU tail first, then W.
  function automatic logic [1:0] fwd_d(input logic [ADDR_W-1:0] s);
    if (s == '0)                              return 2'b00;
    else if (tail(s))                         return 2'b10;
    else if (rd_wr_W_i && (rd_addr_W_i == s)) return 2'b01;
    else                                      return 2'b00;
  endfunction

  logic ld_use, raw_mdu, waw_mdu, stall_int, issue_int;

  // Hazard detection; stall never depends on issue so no loop forms through the scoreboard.
  always_comb begin
    ld_use    = rd_wr_M_i && is_load_M_i && (rd_addr_M_i != '0) &&
                ((rd_addr_M_i == rs1_addr_E_i) || (rd_addr_M_i == rs2_addr_E_i));
    raw_mdu   = pending(rs1_addr_E_i) || pending(rs2_addr_E_i);
    waw_mdu   = rd_wr_E_i && (rd_addr_E_i != '0) && pending(rd_addr_E_i);
    stall_int = !kill_E_i && (ld_use || raw_mdu || waw_mdu);
    issue_int = mdu_op_E_i && rd_wr_E_i && !kill_E_i && !stall_int;
  end

  // Outputs held inactive while reset is asserted.
  always_comb begin
    fwd_rs1_E_o = 2'b00;
    fwd_rs2_E_o = 2'b00;
    fwd_rs1_D_o = 2'b00;
    fwd_rs2_D_o = 2'b00;
    stall_o     = 1'b0;
    mdu_issue_o = 1'b0;
    if (!rst_i) begin
      fwd_rs1_E_o = fwd_e(rs1_addr_E_i);
      fwd_rs2_E_o = fwd_e(rs2_addr_E_i);
      fwd_rs1_D_o = fwd_d(rs1_addr_D_i);
      fwd_rs2_D_o = fwd_d(rs2_addr_D_i);
      stall_o     = stall_int;
      mdu_issue_o = issue_int;
    end
    bubble_M_o = stall_o;
  end

  // Scoreboard shift runs every cycle, independent of stall, since the MDU pipeline never freezes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_valid <= '0;
      for (int i = 0; i < MDU_LAT; i++) sb_rd[i] <= '0;
    end else begin
      sb_valid <= {sb_valid[MDU_LAT-2:0], issue_int};
      sb_rd[0] <= rd_addr_E_i;
      for (int i = 1; i < MDU_LAT; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end

  // In-flight count tracks popcount of valid bits: +1 on issue, -1 on tail drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      case ({issue_int, sb_valid[MDU_LAT-1]})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign mdu_wb_valid_o = sb_valid[MDU_LAT-1];
  assign mdu_wb_rd_o    = sb_rd[MDU_LAT-1];
  assign mdu_inflight_o = inflight_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1_addr_D_i, rs2_addr_D_i, rs1_addr_E_i, rs2_addr_E_i, rd_addr_E_i;
  logic       rd_wr_E_i, mdu_op_E_i, kill_E_i;
  logic       rd_wr_M_i, is_load_M_i, rd_wr_W_i;
  logic [4:0] rd_addr_M_i, rd_addr_W_i;
  logic [1:0] fwd_rs1_E_o, fwd_rs2_E_o, fwd_rs1_D_o, fwd_rs2_D_o;
  logic       stall_o, bubble_M_o, mdu_issue_o, mdu_wb_valid_o;
  logic [4:0] mdu_wb_rd_o;
  logic [2:0] mdu_inflight_o;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard_unit #(.ADDR_W(5), .MDU_LAT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_D_i(rs1_addr_D_i), .rs2_addr_D_i(rs2_addr_D_i),
    .rs1_addr_E_i(rs1_addr_E_i), .rs2_addr_E_i(rs2_addr_E_i),
    .rd_addr_E_i(rd_addr_E_i), .rd_wr_E_i(rd_wr_E_i),
    .mdu_op_E_i(mdu_op_E_i), .kill_E_i(kill_E_i),
    .rd_wr_M_i(rd_wr_M_i), .rd_addr_M_i(rd_addr_M_i), .is_load_M_i(is_load_M_i),
    .rd_wr_W_i(rd_wr_W_i), .rd_addr_W_i(rd_addr_W_i),
    .fwd_rs1_E_o(fwd_rs1_E_o), .fwd_rs2_E_o(fwd_rs2_E_o),
    .fwd_rs1_D_o(fwd_rs1_D_o), .fwd_rs2_D_o(fwd_rs2_D_o),
    .stall_o(stall_o), .bubble_M_o(bubble_M_o), .mdu_issue_o(mdu_issue_o),
    .mdu_wb_valid_o(mdu_wb_valid_o), .mdu_wb_rd_o(mdu_wb_rd_o),
    .mdu_inflight_o(mdu_inflight_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_addr_D_i = 0; rs2_addr_D_i = 0; rs1_addr_E_i = 0; rs2_addr_E_i = 0; rd_addr_E_i = 0;
    rd_wr_E_i = 0; mdu_op_E_i = 0; kill_E_i = 0;
    rd_wr_M_i = 0; rd_addr_M_i = 0; is_load_M_i = 0;
    rd_wr_W_i = 0; rd_addr_W_i = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked #1 later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_mdu(input logic [4:0] rd);
    idle();
    mdu_op_E_i = 1; rd_wr_E_i = 1; rd_addr_E_i = rd;
  endtask

  initial begin
    idle();
    rst_i = 1;
    // Reset: load-use and M-forward conditions present, but everything must read inactive.
    rd_wr_M_i = 1; is_load_M_i = 1; rd_addr_M_i = 3; rs1_addr_E_i = 3;
    rd_wr_W_i = 1; rd_addr_W_i = 4; rs1_addr_D_i = 4; mdu_op_E_i = 1; rd_wr_E_i = 1; rd_addr_E_i = 6;
    #12;
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_M_o, 0);
    chk("rst_issue", mdu_issue_o, 0);
    chk("rst_fwd_d", fwd_rs1_D_o, 0);
    chk("rst_fwd_e", fwd_rs1_E_o, 0);
    chk("rst_wb_valid", mdu_wb_valid_o, 0);
    chk("rst_inflight", mdu_inflight_o, 0);
    cyc(); rst_i = 0; idle();

    // Load-use on rs1
    cyc(); idle();
    rd_wr_M_i = 1; is_load_M_i = 1; rd_addr_M_i = 5; rs1_addr_E_i = 5; rs2_addr_E_i = 2;
    #1;
    chk("lduse_stall", stall_o, 1);
    chk("lduse_bubble", bubble_M_o, 1);
    cyc(); idle();
    rd_wr_W_i = 1; rd_addr_W_i = 5; rs1_addr_E_i = 5; rs2_addr_E_i = 2;
    #1;
    chk("lduse_next_stall", stall_o, 0);
    chk("lduse_fwd_w", fwd_rs1_E_o, 2'b01);

    // ALU back-to-back: M beats W for the same register
    cyc(); idle();
    rd_wr_M_i = 1; rd_addr_M_i = 3; rd_wr_W_i = 1; rd_addr_W_i = 3; rs2_addr_E_i = 3;
    #1;
    chk("alu_fwd_m", fwd_rs2_E_o, 2'b10);
    chk("alu_stall", stall_o, 0);

    // Load to x0 never stalls or forwards
    cyc(); idle();
    rd_wr_M_i = 1; is_load_M_i = 1; rd_addr_M_i = 0; rs1_addr_E_i = 0;
    #1;
    chk("x0_stall", stall_o, 0);
    chk("x0_fwd", fwd_rs1_E_o, 0);

    // MDU RAW: mul x7 at t, dependent add held in E t+1..t+3, forwards 11 at t+4
    cyc(); issue_mdu(7);
    #1;
    chk("raw_issue", mdu_issue_o, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc(); idle();
      rs1_addr_E_i = 7; rd_wr_E_i = 1; rd_addr_E_i = 8;
      #1;
      chk($sformatf("raw_stall_t%0d", k), stall_o, 1);
      chk($sformatf("raw_noissue_t%0d", k), mdu_issue_o, 0);
    end
    cyc(); idle();
    rs1_addr_E_i = 7; rd_wr_E_i = 1; rd_addr_E_i = 8; rs1_addr_D_i = 7;
    rd_wr_M_i = 1; rd_addr_M_i = 7;
    #1;
    chk("raw_t4_stall", stall_o, 0);
    chk("raw_t4_fwd_e", fwd_rs1_E_o, 2'b11);
    chk("raw_t4_fwd_d", fwd_rs1_D_o, 2'b10);
    chk("raw_t4_wb_valid", mdu_wb_valid_o, 1);
    chk("raw_t4_wb_rd", mdu_wb_rd_o, 7);
    chk("raw_t4_inflight", mdu_inflight_o, 1);
    cyc(); idle();
    #1;
    chk("raw_drained", mdu_inflight_o, 0);
    chk("raw_wb_gone", mdu_wb_valid_o, 0);

    // WAW on x9, then the same E instruction killed
    cyc(); issue_mdu(9);
    cyc(); idle();
    rd_wr_E_i = 1; rd_addr_E_i = 9; rs1_addr_E_i = 1;
    #1;
    chk("waw_stall", stall_o, 1);
    mdu_op_E_i = 1; kill_E_i = 1;
    #1;
    chk("waw_kill_stall", stall_o, 0);
    chk("waw_kill_issue", mdu_issue_o, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle();
    end
    #1;
    chk("waw_drained", mdu_inflight_o, 0);

    // Back-to-back issue x1..x6; count saturates at 4 while the tail drains
    for (int k = 0; k < 6; k++) begin
      cyc(); issue_mdu(5'(k + 1));
      if (k == 4) rs1_addr_D_i = 1;
      #1;
      chk($sformatf("b2b_inflight_%0d", k), mdu_inflight_o, (k < 4) ? k : 4);
      chk($sformatf("b2b_issue_%0d", k), mdu_issue_o, 1);
      if (k == 4) begin
        chk("b2b_fwd_d", fwd_rs1_D_o, 2'b10);
        chk("b2b_wb_rd", mdu_wb_rd_o, 1);
      end
    end
    cyc(); idle();
    #1;
    chk("b2b_hold", mdu_inflight_o, 4);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle();
    end
    #1;
    chk("b2b_drained", mdu_inflight_o, 0);

    // Reset mid-flight with three ops outstanding
    for (int k = 0; k < 3; k++) begin
      cyc(); issue_mdu(5'(10 + k));
    end
    cyc(); idle();
    #1;
    chk("mid_inflight3", mdu_inflight_o, 3);
    #1 rst_i = 1;
    #1;
    chk("mid_rst_inflight", mdu_inflight_o, 0);
    chk("mid_rst_wb", mdu_wb_valid_o, 0);
    cyc(); rst_i = 0;
    rs1_addr_E_i = 10; rs2_addr_E_i = 11; rd_wr_E_i = 1; rd_addr_E_i = 12;
    #1;
    chk("mid_post_stall", stall_o, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(); idle();
      #1;
      chk($sformatf("mid_no_wb_%0d", k), mdu_wb_valid_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Next-generation hazard and forwarding unit for the 5-stage RV32 pipeline (F/D/E/M/W), extended with a fixed-latency pipelined multiply/divide unit (MDU).
- Keeps the M/W to E forwarding and the load-use stall.
- Adds a shift-register scoreboard that tracks in-flight MDU writes, with RAW/WAW stalls and MDU-result forwarding.
- Adds forwarding into the decode stage.
- Sits in the control top, beside the pipeline registers.

Parameters:
ADDR_W, 5, register address width (2**ADDR_W architectural regs; reg 0 hard-wired zero)
MDU_LAT, 4, MDU latency in cycles from issue (E) to result (range 2..16)
CNT_W, $clog2(MDU_LAT+1), width of the in-flight counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
rs1_addr_D_i  in  ADDR_W  decode rs1
rs2_addr_D_i  in  ADDR_W  decode rs2
rs1_addr_E_i  in  ADDR_W  execute rs1
rs2_addr_E_i  in  ADDR_W  execute rs2
rd_addr_E_i  in  ADDR_W  execute rd
rd_wr_E_i  in  1  E instruction writes rd
mdu_op_E_i  in  1  E instruction is an MDU op
kill_E_i  in  1  E instruction is being flushed (taken branch)
rd_wr_M_i  in  1  M writes rd
rd_addr_M_i  in  ADDR_W  M rd
is_load_M_i  in  1  M is a load
rd_wr_W_i  in  1  W writes rd
rd_addr_W_i  in  ADDR_W  W rd
fwd_rs1_E_o  out  2  00 RF/ID-EX, 01 W, 10 M, 11 MDU result
fwd_rs2_E_o  out  2  same encoding
fwd_rs1_D_o  out  2  00 RF, 01 W, 10 MDU result
fwd_rs2_D_o  out  2  same encoding
stall_o  out  1  freeze PC, IF/ID and ID/EX
bubble_M_o  out  1  load bubble into EX/MEM
mdu_issue_o  out  1  MDU op accepted this cycle
mdu_wb_valid_o  out  1  MDU result completes this cycle
mdu_wb_rd_o  out  ADDR_W  rd of completing MDU result
mdu_inflight_o  out  CNT_W  number of valid scoreboard entries

Behaviour:
Scoreboard
- sb[0..MDU_LAT-1] holds {valid, rd}, registered.
- Every cycle it shifts: sb[i+1] <= sb[i]; sb[0] <= {mdu_issue_o, rd_addr_E_i}.
- The shift runs regardless of stall_o.
- mdu_wb_valid_o / mdu_wb_rd_o = sb[MDU_LAT-1] (registered, no combinational path). The register file writes that result at the end of the same cycle.
- mdu_inflight_o is a registered counter.
  - +1 on issue, -1 on tail valid.
  - Issue and tail in the same cycle: net 0.
  - It must always equal the popcount of sb valid bits.

Validity terms (all combinational)
- "live": entry valid and rd != 0.
- "pending(r)": r matches a live entry in sb[0..MDU_LAT-2].
- "tail(r)": sb[MDU_LAT-1] is live and rd == r.

Stall
- ld_use = rd_wr_M_i & is_load_M_i & rd_addr_M_i != 0 & rd_addr_M_i matches rs1_addr_E_i or rs2_addr_E_i.
- raw_mdu = pending(rs1_addr_E_i) | pending(rs2_addr_E_i).
- waw_mdu = rd_wr_E_i & rd_addr_E_i != 0 & pending(rd_addr_E_i).
- stall_o = ~kill_E_i & (ld_use | raw_mdu | waw_mdu).
- A killed E instruction never stalls.
- bubble_M_o = stall_o. The frozen E instruction must not enter M twice.
- mdu_issue_o = mdu_op_E_i & rd_wr_E_i & ~kill_E_i & ~stall_o.
- No combinational loop: stall_o does not depend on mdu_issue_o.

E-stage forwarding, per source s, in priority order:
1. s == 0 -> 00.
2. tail(s) -> 11.
3. rd_wr_M_i & ~is_load_M_i & rd_addr_M_i == s -> 10.
4. rd_wr_W_i & rd_addr_W_i == s -> 01.
5. Otherwise 00.
- The MDU tail wins because the WAW stall guarantees it is the youngest producer.

D-stage forwarding, per source s:
1. s == 0 -> 00.
2. tail(s) -> 10.
3. rd_wr_W_i & rd_addr_W_i == s -> 01.
4. Otherwise 00.

Reset
- Asserting rst_i, including mid-operation, immediately clears all sb valid bits and mdu_inflight_o.
- While reset is asserted:
  - all fwd outputs = 00;
  - stall_o, bubble_M_o, mdu_issue_o and mdu_wb_valid_o = 0.
- In-flight MDU results are discarded.

Boundary conditions
- rd = 0 never creates a hazard or a forward.
- When the scoreboard is full, the sb[MDU_LAT-1] entry drains in the same cycle, so issue is always possible (no structural stall).
- A tail-matching source needs no stall; it forwards with code 11.

Test Plan:
- Load-use: lw x5 in M, E rs1=x5 -> stall_o=1 and bubble_M_o=1 for 1 cycle; next cycle load in W gives fwd_rs1_E_o=01.
- ALU back-to-back: M writes x3 (non-load), E rs2=x3, W also writes x3 -> fwd_rs2_E_o=10, stall_o=0.
- MDU RAW (MDU_LAT=4): mul x7 issued at cycle t; add rs1=x7 in E at t+1 -> stall_o=1 for cycles t+1..t+3; at t+4 fwd_rs1_E_o=11, mdu_wb_valid_o=1, mdu_wb_rd_o=7.
- MDU WAW plus kill: mul x9 in flight; E writes x9 -> stall_o=1; same cycle kill_E_i=1 -> stall_o=0 and mdu_issue_o=0.
- Back-to-back issue: 4 MDU ops to x1..x4 on consecutive cycles -> mdu_inflight_o=1,2,3,4, then holds at 4 while issuing; with a decode read of x1 at completion, fwd_rs1_D_o=10.
- Reset mid-flight: 3 ops in flight, pulse rst_i -> mdu_inflight_o=0 at once, no mdu_wb_valid_o afterwards; a source matching a killed rd gives stall_o=0.
